// File: rtl/mem_port_arbiter_if.sv
// Bundle shared by the fetch port, the data port and the memory.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        stall;
  logic        err;

  modport master (
    input  if_req,
    input  if_addr,
    output if_ack,
    output if_rdata,
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata,
    output mem_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata,
    output stall,
    output err
  );

  modport slave (
    output if_req,
    output if_addr,
    input  if_ack,
    input  if_rdata,
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata,
    input  mem_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata,
    input  stall,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data stage first, fetch guaranteed
// progress by a starvation counter; one outstanding access at a time.
module mem_port_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic          r_owner;
  logic          w_owner;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve;
  logic [WW-1:0] r_wd;
  logic [WW-1:0] w_wd;

  logic          r_mem_valid;
  logic          w_mem_valid;
  logic          r_mem_we;
  logic          w_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   w_mem_wdata;

  logic          r_if_ack;
  logic          w_if_ack;
  logic          r_dm_ack;
  logic          w_dm_ack;
  logic [31:0]   r_if_rdata;
  logic [31:0]   w_if_rdata;
  logic [31:0]   r_dm_rdata;
  logic [31:0]   w_dm_rdata;
  logic          r_err;
  logic          w_err;

  logic          w_both;
  logic          w_pick_if;
  logic          w_grant;
  logic          w_fin;
  logic [31:0]   w_res;

  // The ack cycle blocks a new grant so a held req is not issued twice.
  assign w_both    = bus.if_req & bus.dm_req;
  assign w_pick_if = bus.if_req &
                     (~bus.dm_req | (r_starve >= STARVE_MAX));
  assign w_grant   = (r_state == S_IDLE) &
                     ~(r_if_ack | r_dm_ack) &
                     (bus.if_req | bus.dm_req);

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_starve    = r_starve;
    w_wd        = r_wd;
    w_mem_valid = r_mem_valid;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_ack    = 1'b0;
    w_dm_ack    = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_err       = 1'b0;
    w_fin       = 1'b0;
    w_res       = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state     = S_ISSUE;
          w_mem_valid = 1'b1;
          w_owner     = ~w_pick_if;
          unique case (1'b1)
            w_pick_if: begin
              w_starve    = '0;
              w_mem_we    = 1'b0;
              w_mem_addr  = bus.if_addr;
              w_mem_wdata = '0;
            end
            default: begin
              if (w_both)
                w_starve = r_starve + 1'b1;
              w_mem_we    = bus.dm_we;
              w_mem_addr  = bus.dm_addr;
              w_mem_wdata = bus.dm_wdata;
            end
          endcase
        end
      end

      S_ISSUE: begin
        if (bus.mem_ready) begin
          w_state     = S_WAIT;
          w_mem_valid = 1'b0;
          w_wd        = '0;
        end
      end

      S_WAIT: begin
        unique case (1'b1)
          bus.mem_rvalid: begin
            w_fin = 1'b1;
            w_res = bus.mem_rdata;
          end
          (r_wd == WD_LAST): begin
            w_fin = 1'b1;
            w_res = 32'hDEAD_BEEF;
            w_err = 1'b1;
          end
          default: w_wd = r_wd + 1'b1;
        endcase
        if (w_fin) begin
          w_state  = S_IDLE;
          w_wd     = '0;
          w_if_ack = ~r_owner;
          w_dm_ack = r_owner;
          if (r_owner)
            w_dm_rdata = w_res;
          else
            w_if_rdata = w_res;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_starve    <= '0;
      r_wd        <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_starve    <= w_starve;
      r_wd        <= w_wd;
      r_mem_valid <= w_mem_valid;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_ack    <= w_if_ack;
      r_dm_ack    <= w_dm_ack;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_err       <= w_err;
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.err       = r_err;

  assign bus.stall = (bus.if_req & ~r_if_ack) |
                     (bus.dm_req & ~r_dm_ack);
endmodule
